// File: rtl/simd_wave_scheduler_pkg.sv
// simd_wave_scheduler_pkg: shared types and default sizes for the wave scheduler (package gpu_sched_pkg)
package gpu_sched_pkg;
  localparam int SCHED_NUM_SIMD = 4;
  localparam int SCHED_WAVE_ID_WIDTH = 8;
  localparam int RR_PTR_W = $clog2(SCHED_NUM_SIMD);
  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/simd_wave_scheduler_if.sv
// simd_wave_scheduler_if: launch, completion and per-SIMD PC control signals of the wave scheduler
// master = launcher/datapath side, slave = scheduler; busy_cycles exists only with SCHED_PERF_CNT_EN
interface simd_wave_scheduler_if
  import gpu_sched_pkg::*;
#(
  parameter int NUM_SIMD = SCHED_NUM_SIMD,
  parameter int WAVE_ID_WIDTH = SCHED_WAVE_ID_WIDTH
);
  logic enable;
  logic start;
  logic [WAVE_ID_WIDTH-1:0] total_waves;
  logic [NUM_SIMD-1:0] simd_done;
  logic [NUM_SIMD-1:0] dispatch_new_wave;
  logic [NUM_SIMD*WAVE_ID_WIDTH-1:0] dispatch_wave_id;
  logic [NUM_SIMD-1:0] update_pc;
  logic [NUM_SIMD-1:0] simd_busy;
  logic all_done;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] busy_cycles;
  modport master(output enable, start, total_waves, simd_done,
                 input dispatch_new_wave, dispatch_wave_id, update_pc, simd_busy, all_done, busy_cycles);
  modport slave(input enable, start, total_waves, simd_done,
                output dispatch_new_wave, dispatch_wave_id, update_pc, simd_busy, all_done, busy_cycles);
`else
  modport master(output enable, start, total_waves, simd_done,
                 input dispatch_new_wave, dispatch_wave_id, update_pc, simd_busy, all_done);
  modport slave(input enable, start, total_waves, simd_done,
                output dispatch_new_wave, dispatch_wave_id, update_pc, simd_busy, all_done);
`endif
endinterface

// File: rtl/simd_wave_scheduler_rr_free_picker.sv
// rr_free_picker: combinational round-robin pick of the first free unit at or after ptr
// ports: free (mask), ptr (start index) -> found, onehot, winner
module rr_free_picker #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  free,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] winner
);
  // Scan offsets from farthest to nearest so the nearest free unit wins; index wraps since N is a power of two.
  always_comb begin
    found = 1'b0;
    winner = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (free[ptr + PW'(k)]) begin
        found = 1'b1;
        winner = ptr + PW'(k);
      end
    end
    onehot = found ? N'(1) << winner : '0;
  end
endmodule

// File: rtl/simd_wave_scheduler.sv
// simd_wave_scheduler: dispatches a launch's waves round-robin onto NUM_SIMD units, one wave per unit
// ports: clk, rst (sync, active-high), bus (simd_wave_scheduler_if.slave: enable, start, total_waves,
//   simd_done in; dispatch_new_wave, dispatch_wave_id, update_pc, simd_busy, all_done out)
// SCHED_PERF_CNT_EN adds bus.busy_cycles, a saturating count of enabled DISPATCH/WAIT cycles
module simd_wave_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int NUM_SIMD = SCHED_NUM_SIMD,
  parameter int WAVE_ID_WIDTH = SCHED_WAVE_ID_WIDTH
) (
  input logic clk,
  input logic rst,
  simd_wave_scheduler_if.slave bus
);
  localparam int N = NUM_SIMD;
  localparam int W = WAVE_ID_WIDTH;
  localparam int PW = $clog2(N);
  sched_state_t state, state_next;
  logic [W-1:0] total_q, dispatched, completed, done_cnt;
  logic [PW-1:0] rr_ptr, winner;
  logic [N-1:0] busy, dnw, done_ok, pick_oh;
  logic [N-1:0][W-1:0] ids;
  logic all_done_q, found, do_start, do_disp, to_done;
  // Only pulses from units holding a wave retire anything; stray pulses fall away here.
  assign done_ok = bus.simd_done & busy;
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < N; i++) done_cnt = done_cnt + W'(done_ok[i]);
  end
  // Registered busy is the candidate set, so a unit freed this cycle waits one cycle.
  rr_free_picker #(.N(N)) u_pick (
    .free(~busy),
    .ptr(rr_ptr),
    .found(found),
    .onehot(pick_oh),
    .winner(winner)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  // WAIT looks ahead at this cycle's completions so all_done follows the last retirement by one cycle.
  always_comb begin
    state_next = state;
    do_start = 1'b0;
    do_disp = 1'b0;
    to_done = 1'b0;
    if (bus.enable) begin
      case (state)
        IDLE, DONE: begin
          do_start = bus.start;
          state_next = bus.start ? (bus.total_waves == '0 ? DONE : DISPATCH) : state;
        end
        DISPATCH: begin
          do_disp = found;
          state_next = found && dispatched + W'(1) == total_q ? WAIT : DISPATCH;
        end
        WAIT: begin
          to_done = completed + done_cnt == total_q;
          state_next = to_done ? DONE : WAIT;
        end
        default: state_next = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      dispatched <= '0;
      completed <= '0;
      rr_ptr <= '0;
      busy <= '0;
      dnw <= '0;
      ids <= '0;
      all_done_q <= 1'b0;
    end else begin
      busy <= (busy & ~done_ok) | (do_disp ? pick_oh : '0);
      completed <= do_start ? '0 : completed + done_cnt;
      dnw <= do_disp ? pick_oh : '0;
      if (do_start) begin
        total_q <= bus.total_waves;
        dispatched <= '0;
        all_done_q <= bus.total_waves == '0;
      end
      if (do_disp) begin
        ids[winner] <= dispatched;
        dispatched <= dispatched + W'(1);
        rr_ptr <= winner + PW'(1);
      end
      if (to_done) all_done_q <= 1'b1;
    end
  end
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] busy_cycles_q;
  always_ff @(posedge clk) begin
    if (rst || do_start) busy_cycles_q <= '0;
    else if (bus.enable && (state == DISPATCH || state == WAIT) && !(&busy_cycles_q)) busy_cycles_q <= busy_cycles_q + 32'd1;
  end
  assign bus.busy_cycles = busy_cycles_q;
`endif
  assign bus.dispatch_new_wave = dnw;
  assign bus.dispatch_wave_id = ids;
  assign bus.update_pc = {N{bus.enable}} & busy & ~dnw;
  assign bus.simd_busy = busy;
  assign bus.all_done = all_done_q;
endmodule

// File: tb/tb_simd_wave_scheduler.sv
// tb_simd_wave_scheduler: vector table plus directed launches, with a dispatch scoreboard
module tb_simd_wave_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  simd_wave_scheduler_if #(.NUM_SIMD(4), .WAVE_ID_WIDTH(8)) bus ();
  simd_wave_scheduler #(.NUM_SIMD(4), .WAVE_ID_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic en;
    logic st;
    logic [7:0] tot;
    logic [3:0] dn;
    logic [3:0] e_dnw;
    logic [3:0] e_busy;
    logic [3:0] e_upc;
    logic e_ad;
  } row_t;
  typedef struct {
    int unit;
    logic [7:0] id;
  } exp_t;
  row_t vec[10];
  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Every dispatch pulse must match the next expected (unit, wave id) pair and never overlap update_pc.
  task automatic mon();
    exp_t e;
    logic [3:0] oh;
    if (|bus.dispatch_new_wave) begin
      chk("pulse_vs_update_pc", 64'(bus.dispatch_new_wave & bus.update_pc), 64'd0);
      if (q.size() == 0) chk("unexpected_dispatch", 64'(bus.dispatch_new_wave), 64'd0);
      else begin
        e = q.pop_front();
        oh = 4'b0001 << e.unit;
        chk("dispatch_unit", 64'(bus.dispatch_new_wave), 64'(oh));
        chk("dispatch_id", 64'(bus.dispatch_wave_id[e.unit*8 +: 8]), 64'(e.id));
      end
    end
  endtask
  task automatic cyc(input logic en, input logic st, input logic [7:0] tot, input logic [3:0] dn);
    @(negedge clk);
    bus.enable = en;
    bus.start = st;
    bus.total_waves = tot;
    bus.simd_done = dn;
    #1;
    mon();
  endtask
  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.start = 1'b0;
    bus.total_waves = '0;
    bus.simd_done = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask
  task automatic push(input int u, input logic [7:0] id);
    exp_t e;
    e.unit = u;
    e.id = id;
    q.push_back(e);
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.start = 1'b0;
    bus.total_waves = '0;
    bus.simd_done = '0;
    vec[0] = '{1'b1, 1'b1, 8'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vec[1] = '{1'b1, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vec[2] = '{1'b1, 1'b0, 8'd0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0};
    vec[3] = '{1'b1, 1'b0, 8'd0, 4'b0000, 4'b0010, 4'b0011, 4'b0001, 1'b0};
    vec[4] = '{1'b1, 1'b0, 8'd0, 4'b0001, 4'b0100, 4'b0111, 4'b0011, 1'b0};
    vec[5] = '{1'b1, 1'b0, 8'd0, 4'b0110, 4'b0000, 4'b0110, 4'b0110, 1'b0};
    vec[6] = '{1'b1, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vec[7] = '{1'b0, 1'b1, 8'd5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vec[8] = '{1'b1, 1'b0, 8'd0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    vec[9] = '{1'b1, 1'b0, 8'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
    do_rst();
    #1;
    chk("rst_dnw", 64'(bus.dispatch_new_wave), 64'd0);
    chk("rst_ids", 64'(bus.dispatch_wave_id), 64'd0);
    chk("rst_busy", 64'(bus.simd_busy), 64'd0);
    chk("rst_all_done", 64'(bus.all_done), 64'd0);
    // three waves onto three free units, then staggered completion
    push(0, 8'd0);
    push(1, 8'd1);
    push(2, 8'd2);
    for (int i = 0; i < 10; i++) begin
      cyc(vec[i].en, vec[i].st, vec[i].tot, vec[i].dn);
      chk($sformatf("row%0d_dnw", i), 64'(bus.dispatch_new_wave), 64'(vec[i].e_dnw));
      chk($sformatf("row%0d_busy", i), 64'(bus.simd_busy), 64'(vec[i].e_busy));
      chk($sformatf("row%0d_upc", i), 64'(bus.update_pc), 64'(vec[i].e_upc));
      chk($sformatf("row%0d_all_done", i), 64'(bus.all_done), 64'(vec[i].e_ad));
    end
    // zero-wave launch from IDLE
    do_rst();
    cyc(1'b1, 1'b1, 8'd0, 4'b0000);
    chk("zero_before", 64'(bus.all_done), 64'd0);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("zero_all_done", 64'(bus.all_done), 64'd1);
    chk("zero_busy", 64'(bus.simd_busy), 64'd0);
    // stall on full units, refill two cycles after a completion, spurious done ignored
    do_rst();
    push(0, 8'd0); push(1, 8'd1); push(2, 8'd2); push(3, 8'd3); push(2, 8'd4); push(0, 8'd5);
    cyc(1'b1, 1'b1, 8'd6, 4'b0000);
    repeat (5) cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("stall_dnw", 64'(bus.dispatch_new_wave), 64'd0);
    chk("stall_busy", 64'(bus.simd_busy), 64'hf);
    cyc(1'b1, 1'b0, 8'd0, 4'b0100);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("refill_not_yet", 64'(bus.dispatch_new_wave), 64'd0);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("refill_unit2", 64'(bus.dispatch_new_wave), 64'h4);
    cyc(1'b1, 1'b0, 8'd0, 4'b0001);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("wrap_unit0", 64'(bus.dispatch_new_wave), 64'h1);
    cyc(1'b1, 1'b0, 8'd0, 4'b0001);
    cyc(1'b1, 1'b0, 8'd0, 4'b1011);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("spurious_all_done", 64'(bus.all_done), 64'd0);
    chk("multi_done_busy", 64'(bus.simd_busy), 64'h4);
    cyc(1'b1, 1'b0, 8'd0, 4'b0100);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("launch_a_all_done", 64'(bus.all_done), 64'd1);
    chk("launch_a_busy", 64'(bus.simd_busy), 64'd0);
    // rr_ptr=2 with units 2,3 busy picks unit 0; then reset in WAIT
    do_rst();
    push(0, 8'd0); push(1, 8'd1); push(2, 8'd2); push(3, 8'd3); push(1, 8'd4); push(0, 8'd5);
    cyc(1'b1, 1'b1, 8'd6, 4'b0000);
    repeat (5) cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0010);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0011);
    chk("ptr2_refill_unit1", 64'(bus.dispatch_new_wave), 64'h2);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("ptr2_pick_unit0", 64'(bus.dispatch_new_wave), 64'h1);
    chk("ptr2_busy", 64'(bus.simd_busy), 64'hd);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wait_rst_dnw", 64'(bus.dispatch_new_wave), 64'd0);
    chk("wait_rst_ids", 64'(bus.dispatch_wave_id), 64'd0);
    chk("wait_rst_busy", 64'(bus.simd_busy), 64'd0);
    chk("wait_rst_upc", 64'(bus.update_pc), 64'd0);
    chk("wait_rst_all_done", 64'(bus.all_done), 64'd0);
    chk("sb_drained_b", 64'(q.size()), 64'd0);
    // enable low for 5 cycles with a completion inside; start during DISPATCH ignored
    do_rst();
    push(0, 8'd0); push(1, 8'd1); push(2, 8'd2); push(3, 8'd3); push(0, 8'd4); push(1, 8'd5);
    cyc(1'b1, 1'b1, 8'd6, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'd0, i == 3 ? 4'b0001 : 4'b0000);
      chk($sformatf("hold%0d_upc", i), 64'(bus.update_pc), 64'd0);
      if (i > 0) chk($sformatf("hold%0d_dnw", i), 64'(bus.dispatch_new_wave), 64'd0);
    end
    chk("hold_done_counted_busy", 64'(bus.simd_busy), 64'd0);
    cyc(1'b1, 1'b1, 8'd2, 4'b0000);
    repeat (4) cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b1111);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    cyc(1'b1, 1'b0, 8'd0, 4'b0010);
    chk("last_wave_unit1", 64'(bus.dispatch_new_wave), 64'h2);
    cyc(1'b1, 1'b0, 8'd0, 4'b0000);
    chk("launch_c_all_done", 64'(bus.all_done), 64'd1);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
